// File: rtl/regfile_pkg.sv
// Shared constants for the GPR file: register count, address width, byte lanes
// and the all-zero word used for reset and masked reads.
package regfile_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_AW     = 5;
    localparam int BYTE_LANES = 4;
    localparam int WORD_W     = BYTE_LANES * 8;

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_hilo_reg.sv
// HI/LO storage with independent write enables and an optional same-cycle
// forwarding mux; outputs are held at zero while reset is asserted.
module hilo_reg
    import regfile_pkg::*;
#(
    parameter int DW     = WORD_W,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hi_en,
    input  logic          lo_en,
    input  logic [DW-1:0] hi_data,
    input  logic [DW-1:0] lo_data,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_en) hi_q <= hi_data;
            if (lo_en) lo_q <= lo_data;
        end
    end

    always_comb begin
        hi = '0;
        lo = '0;
        if (rst_n) begin
            hi = (BYPASS != 0 && hi_en) ? hi_data : hi_q;
            lo = (BYPASS != 0 && lo_en) ? lo_data : lo_q;
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural GPR file with byte-enabled write port, two combinational read
// ports with write->read forwarding, and the HI/LO pair.
module regfile
    import regfile_pkg::*;
#(
    parameter int DW     = WORD_W,
    parameter int AW     = REG_AW,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BYTE_LANES-1:0] wb_wren_i,
    input  logic [AW-1:0]         wb_waddr_i,
    input  logic [DW-1:0]         wb_wdata_i,
    input  logic                  wb_whien_i,
    input  logic                  wb_wloen_i,
    input  logic [DW-1:0]         wb_hi_i,
    input  logic [DW-1:0]         wb_lo_i,
    input  logic                  rf_re1_i,
    input  logic [AW-1:0]         rf_raddr1_i,
    output logic [DW-1:0]         rf_rdata1_o,
    input  logic                  rf_re2_i,
    input  logic [AW-1:0]         rf_raddr2_i,
    output logic [DW-1:0]         rf_rdata2_o,
    output logic [DW-1:0]         hi_o,
    output logic [DW-1:0]         lo_o
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0] gpr [NREGS];

    function automatic logic [DW-1:0] byte_merge(
        input logic [DW-1:0]         old_word,
        input logic [DW-1:0]         new_word,
        input logic [BYTE_LANES-1:0] en
    );
        logic [DW-1:0] res;
        res = old_word;
        for (int b = 0; b < BYTE_LANES; b++) begin
            if (en[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    // Forwarding only fires when a write is really happening to the same
    // register; r0 and disabled ports short-circuit to zero first.
    function automatic logic [DW-1:0] read_mux(
        input logic          re,
        input logic [AW-1:0] raddr,
        input logic [DW-1:0] stored
    );
        logic [DW-1:0] res;
        res = '0;
        if (re && raddr != '0) begin
            if (BYPASS != 0 && raddr == wb_waddr_i && wb_wren_i != '0)
                res = byte_merge(stored, wb_wdata_i, wb_wren_i);
            else
                res = stored;
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) gpr[r] <= ZERO_WORD;
        end else if (wb_waddr_i != '0) begin
            for (int b = 0; b < BYTE_LANES; b++) begin
                if (wb_wren_i[b]) gpr[wb_waddr_i][8*b +: 8] <= wb_wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        rf_rdata1_o = '0;
        rf_rdata2_o = '0;
        if (rst_n) begin
            rf_rdata1_o = read_mux(rf_re1_i, rf_raddr1_i, gpr[rf_raddr1_i]);
            rf_rdata2_o = read_mux(rf_re2_i, rf_raddr2_i, gpr[rf_raddr2_i]);
        end
    end

    hilo_reg #(
        .DW     (DW),
        .BYPASS (BYPASS)
    ) u_hilo (
        .clk     (clk),
        .rst_n   (rst_n),
        .hi_en   (wb_whien_i),
        .lo_en   (wb_wloen_i),
        .hi_data (wb_hi_i),
        .lo_data (wb_lo_i),
        .hi      (hi_o),
        .lo      (lo_o)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the selected output.
module tb_regfile;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [1:0] SEL_RD1 = 2'd0;
    localparam logic [1:0] SEL_RD2 = 2'd1;
    localparam logic [1:0] SEL_HI  = 2'd2;
    localparam logic [1:0] SEL_LO  = 2'd3;

    logic          clk;
    logic          rst_n;
    logic [3:0]    wb_wren_i;
    logic [AW-1:0] wb_waddr_i;
    logic [DW-1:0] wb_wdata_i;
    logic          wb_whien_i;
    logic          wb_wloen_i;
    logic [DW-1:0] wb_hi_i;
    logic [DW-1:0] wb_lo_i;
    logic          rf_re1_i;
    logic [AW-1:0] rf_raddr1_i;
    logic [DW-1:0] rf_rdata1_o;
    logic          rf_re2_i;
    logic [AW-1:0] rf_raddr2_i;
    logic [DW-1:0] rf_rdata2_o;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    logic [DW-1:0] exp_q[$];
    logic [1:0]    sel_q[$];
    int            total;
    int            bad;

    regfile #(.DW(DW), .AW(AW), .BYPASS(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_wren_i   (wb_wren_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .wb_whien_i  (wb_whien_i),
        .wb_wloen_i  (wb_wloen_i),
        .wb_hi_i     (wb_hi_i),
        .wb_lo_i     (wb_lo_i),
        .rf_re1_i    (rf_re1_i),
        .rf_raddr1_i (rf_raddr1_i),
        .rf_rdata1_o (rf_rdata1_o),
        .rf_re2_i    (rf_re2_i),
        .rf_raddr2_i (rf_raddr2_i),
        .rf_rdata2_o (rf_rdata2_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_wren_i   = '0;
        wb_waddr_i  = '0;
        wb_wdata_i  = '0;
        wb_whien_i  = 1'b0;
        wb_wloen_i  = 1'b0;
        wb_hi_i     = '0;
        wb_lo_i     = '0;
        rf_re1_i    = 1'b0;
        rf_raddr1_i = '0;
        rf_re2_i    = 1'b0;
        rf_raddr2_i = '0;
    endtask

    task automatic gpr_write(input logic [3:0] en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_wren_i  = en;
        wb_waddr_i = a;
        wb_wdata_i = d;
    endtask

    task automatic read1(input logic re, input logic [AW-1:0] a);
        rf_re1_i    = re;
        rf_raddr1_i = a;
    endtask

    task automatic read2(input logic re, input logic [AW-1:0] a);
        rf_re2_i    = re;
        rf_raddr2_i = a;
    endtask

    task automatic expect_out(input logic [1:0] sel, input logic [DW-1:0] val);
        sel_q.push_back(sel);
        exp_q.push_back(val);
    endtask

    // scoreboard monitor
    logic [DW-1:0] mon_exp;
    logic [DW-1:0] mon_got;
    logic [1:0]    mon_sel;
    string         mon_name;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_sel = sel_q.pop_front();
            case (mon_sel)
                SEL_RD1: begin mon_got = rf_rdata1_o; mon_name = "rdata1"; end
                SEL_RD2: begin mon_got = rf_rdata2_o; mon_name = "rdata2"; end
                SEL_HI:  begin mon_got = hi_o;        mon_name = "hi";     end
                default: begin mon_got = lo_o;        mon_name = "lo";     end
            endcase
            total++;
            if (mon_got !== mon_exp) begin
                bad++;
                $display("FAIL %s at %0t: got=%h exp=%h", mon_name, $time, mon_got, mon_exp);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Writes during reset are ignored and reads stay zero.
        step();
        gpr_write(4'hF, 5'd3, 32'h12345678);
        read1(1'b1, 5'd3);
        expect_out(SEL_RD1, 32'h0);
        step();
        step();
        idle_inputs();
        rst_n = 1'b1;

        // All registers read zero on both ports after reset.
        for (int a = 0; a < REG_NUM; a++) begin
            read1(1'b1, AW'(a));
            read2(1'b1, AW'(a));
            expect_out(SEL_RD1, 32'h0);
            expect_out(SEL_RD2, 32'h0);
            if (a == 0) begin
                expect_out(SEL_HI, 32'h0);
                expect_out(SEL_LO, 32'h0);
            end
            step();
        end

        // Full-word write to r5, forwarded this cycle, stored next cycle.
        gpr_write(4'hF, 5'd5, 32'hDEADBEEF);
        read1(1'b1, 5'd5);
        read2(1'b1, 5'd6);
        expect_out(SEL_RD1, 32'hDEADBEEF);
        expect_out(SEL_RD2, 32'h0);
        step();
        gpr_write(4'h0, 5'd5, 32'h0);
        expect_out(SEL_RD1, 32'hDEADBEEF);
        step();

        // Partial-byte write with both ports on the same address.
        gpr_write(4'b0011, 5'd5, 32'h00001234);
        read1(1'b1, 5'd5);
        read2(1'b1, 5'd5);
        expect_out(SEL_RD2, 32'hDEAD1234);
        expect_out(SEL_RD1, 32'hDEAD1234);
        step();
        gpr_write(4'h0, 5'd0, 32'h0);
        expect_out(SEL_RD2, 32'hDEAD1234);
        step();

        // r0 is never written; disabled port reads zero.
        gpr_write(4'hF, 5'd0, 32'hFFFFFFFF);
        read1(1'b1, 5'd0);
        read2(1'b0, 5'd5);
        expect_out(SEL_RD1, 32'h0);
        expect_out(SEL_RD2, 32'h0);
        step();
        gpr_write(4'h0, 5'd0, 32'h0);
        expect_out(SEL_RD1, 32'h0);
        expect_out(SEL_RD2, 32'h0);
        step();

        // HI only; LO untouched.
        wb_whien_i = 1'b1;
        wb_hi_i    = 32'h11;
        wb_wloen_i = 1'b0;
        wb_lo_i    = 32'h99;
        expect_out(SEL_HI, 32'h11);
        expect_out(SEL_LO, 32'h0);
        step();
        wb_whien_i = 1'b0;
        wb_hi_i    = 32'h77;
        expect_out(SEL_HI, 32'h11);
        expect_out(SEL_LO, 32'h0);
        step();

        // LO only, plus a simultaneous GPR and HI write.
        wb_wloen_i = 1'b1;
        wb_lo_i    = 32'h22;
        expect_out(SEL_LO, 32'h22);
        expect_out(SEL_HI, 32'h11);
        step();
        wb_wloen_i = 1'b0;
        wb_whien_i = 1'b1;
        wb_hi_i    = 32'h33;
        gpr_write(4'hF, 5'd9, 32'h12345678);
        read1(1'b1, 5'd9);
        expect_out(SEL_RD1, 32'h12345678);
        expect_out(SEL_LO, 32'h22);
        step();
        wb_whien_i = 1'b0;
        gpr_write(4'h0, 5'd0, 32'h0);
        expect_out(SEL_RD1, 32'h12345678);
        expect_out(SEL_HI, 32'h33);
        step();

        // Non-contiguous byte enables.
        gpr_write(4'b1010, 5'd9, 32'hAABBCCDD);
        read2(1'b1, 5'd9);
        expect_out(SEL_RD2, 32'hAA34CC78);
        step();
        gpr_write(4'h0, 5'd0, 32'h0);
        expect_out(SEL_RD2, 32'hAA34CC78);
        step();

        // Reset in the middle of a cycle clears everything.
        gpr_write(4'hF, 5'd7, 32'hA5A5A5A5);
        step();
        gpr_write(4'h0, 5'd0, 32'h0);
        read1(1'b1, 5'd7);
        expect_out(SEL_RD1, 32'hA5A5A5A5);
        step();
        #1;
        rst_n = 1'b0;
        expect_out(SEL_RD1, 32'h0);
        expect_out(SEL_HI, 32'h0);
        expect_out(SEL_LO, 32'h0);
        step();
        gpr_write(4'hF, 5'd7, 32'h0BADF00D);
        step();
        gpr_write(4'h0, 5'd0, 32'h0);
        rst_n = 1'b1;
        read1(1'b1, 5'd7);
        read2(1'b1, 5'd9);
        expect_out(SEL_RD1, 32'h0);
        expect_out(SEL_RD2, 32'h0);
        expect_out(SEL_HI, 32'h0);
        expect_out(SEL_LO, 32'h0);
        step();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
